host_arbiter: RTL and testbench
===============================

HOST_ARBITER -- requirements
Module: host_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, meaning the memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the memory data width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 The block SHALL provide these ports, one per line:
- host_clk_i  in  1  clock; all logic is rising-edge.
- reset_i  in  1  synchronous, active-high reset.
- a_req_i  in  1  requester A access request.
- a_wr_i  in  1  requester A write (1) or read (0).
- a_addr_i  in  ADDR_W  requester A address.
- a_wdata_i  in  DATA_W  requester A write data.
- a_ack_o  out  1  requester A access complete, one-cycle pulse.
- a_rdata_o  out  DATA_W  requester A read data, valid with a_ack_o.
- b_req_i, b_wr_i, b_addr_i, b_wdata_i, b_ack_o, b_rdata_o  same as A, for requester B.
- host_sel_o  out  1  memory select.
- host_wr_o  out  1  memory write strobe.
- host_addr_o  out  ADDR_W  memory address.
- host_wdata_o  out  DATA_W  memory write data.
- host_rdata_i  in  DATA_W  memory combinational read data, valid in the same cycle as host_sel_o with host_wr_o=0.
- busy_o  out  1  high in every state except IDLE.
- a_count_o, b_count_o  out  8  completed accesses per requester, saturating at 255.

Function
REQ-005 The controller SHALL be an FSM with states IDLE, ISSUE and ACK; the transitions are IDLE->ISSUE when any req is high, ISSUE->ACK always, and ACK->IDLE always.
REQ-006 In IDLE with at least one req high, the block SHALL pick a winner, latch that requester's wr, addr and wdata, and record the winner.
REQ-007 Arbitration SHALL be round-robin:
- If only one requester asks, that requester wins.
- If both ask, the requester not granted most recently wins.
- After reset, A has priority.
REQ-008 In ISSUE, the block SHALL drive host_sel_o=1, and SHALL drive host_wr_o, host_addr_o and host_wdata_o from the latched command.
REQ-009 The block SHALL drive host_sel_o=0 and host_wr_o=0 in every state other than ISSUE; host_addr_o and host_wdata_o SHALL be 0 outside ISSUE.
REQ-010 In ISSUE for a read, the block SHALL register host_rdata_i into the winner's rdata register; for a write, the winner's rdata register SHALL be left unchanged.
REQ-011 In ACK, the block SHALL pulse the winner's ack_o for exactly one cycle, and the winner's rdata_o SHALL hold the captured value.
REQ-012 rdata_o SHALL hold its value until that requester's next read completes.
REQ-013 Latency SHALL be: req sampled high in IDLE at cycle N; memory access at N+1; ack at N+2; back in IDLE at N+3.
REQ-014 Throughput SHALL be one access per 3 cycles.
REQ-015 A requester SHALL hold req and its command stable until its ack; it MAY keep req high after ack to queue its next access, which is evaluated in the following IDLE cycle.
REQ-016 If req drops before ack (a protocol violation), the latched command SHALL still complete and the ack SHALL still be issued.
REQ-017 The loser of a simultaneous request SHALL be granted at the next IDLE if its req is still high; its worst-case wait is 3 cycles.
REQ-018 A count SHALL increment on each ack to its requester and SHALL saturate at 255 without wrapping.
REQ-019 The FSM SHALL never grant both requesters in one access, and SHALL never assert both acks in one cycle.

Reset
REQ-020 When reset_i is high at a clock edge, the block SHALL enter IDLE and SHALL clear all outputs, both rdata registers, both counts, the latched command, and the last-grant pointer (so A has priority).
REQ-021 Reset during ISSUE or ACK SHALL abort the access: no ack is issued and the count is not incremented; a write driven in the ISSUE cycle of that same edge MAY have reached memory.
REQ-022 After reset is released, the first grant SHALL occur no earlier than the first IDLE cycle with reset_i low.

Verification
REQ-023 The bench SHALL check: A writes 0x5A to addr 3, then A reads addr 3 -> host_wr_o=1/addr 3/wdata 0x5A in the first ISSUE, and a_rdata_o=0x5A with a_ack_o at cycle N+2 of the read.
REQ-024 The bench SHALL check: A and B request simultaneously after reset, both held high -> grant order A, B, A, B; acks 3 cycles apart; never both acks high.
REQ-025 The bench SHALL check: B reads addr 15 while host_rdata_i=0xC3 -> b_rdata_o=0xC3, and a_rdata_o unchanged.
REQ-026 The bench SHALL check: 260 A accesses -> a_count_o=255, b_count_o=0.
REQ-027 The bench SHALL check: reset_i asserted in ISSUE of an A read -> no a_ack_o, a_count_o=0, busy_o=0 on the next cycle.
REQ-028 The bench SHALL check: a_req_i dropped in the ISSUE cycle -> a_ack_o still pulses at N+2, and no new grant occurs afterwards.

Source files
------------

// File: rtl/host_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory with combinational read data.
// Each access runs IDLE -> ISSUE -> ACK, so the block completes one access every three cycles.
module host_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              host_clk_i,
    input  logic              reset_i,
    input  logic              a_req_i,
    input  logic              a_wr_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_ack_o,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_req_i,
    input  logic              b_wr_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_ack_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic              host_sel_o,
    output logic              host_wr_o,
    output logic [ADDR_W-1:0] host_addr_o,
    output logic [DATA_W-1:0] host_wdata_o,
    input  logic [DATA_W-1:0] host_rdata_i,
    output logic              busy_o,
    output logic [7:0]        a_count_o,
    output logic [7:0]        b_count_o
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StAck
    } state_e;

    state_e              state_q;
    logic                win_b_q;
    logic                prio_b_q;
    logic                sel_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                a_ack_q;
    logic                b_ack_q;
    logic [DATA_W-1:0]   a_rdata_q;
    logic [DATA_W-1:0]   b_rdata_q;
    logic [7:0]          a_cnt_q;
    logic [7:0]          b_cnt_q;
    logic                pick_b_d;

    // B wins when it is the only requester, or when both ask and B holds priority.
    always_comb begin
        pick_b_d = b_req_i & (~a_req_i | prio_b_q);
    end

    always_ff @(posedge host_clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            win_b_q   <= 1'b0;
            prio_b_q  <= 1'b0;
            sel_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            a_cnt_q   <= 8'd0;
            b_cnt_q   <= 8'd0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (a_req_i || b_req_i) begin
                        state_q  <= StIssue;
                        win_b_q  <= pick_b_d;
                        prio_b_q <= ~pick_b_d;
                        sel_q    <= 1'b1;
                        wr_q     <= pick_b_d ? b_wr_i : a_wr_i;
                        addr_q   <= pick_b_d ? b_addr_i : a_addr_i;
                        wdata_q  <= pick_b_d ? b_wdata_i : a_wdata_i;
                    end
                end
                StIssue: begin
                    // The access completes from the latched command regardless of req.
                    state_q <= StAck;
                    sel_q   <= 1'b0;
                    wr_q    <= 1'b0;
                    addr_q  <= '0;
                    wdata_q <= '0;
                    if (win_b_q) begin
                        b_ack_q <= 1'b1;
                        if (!wr_q) begin
                            b_rdata_q <= host_rdata_i;
                        end
                        if (b_cnt_q != 8'hFF) begin
                            b_cnt_q <= b_cnt_q + 8'd1;
                        end
                    end else begin
                        a_ack_q <= 1'b1;
                        if (!wr_q) begin
                            a_rdata_q <= host_rdata_i;
                        end
                        if (a_cnt_q != 8'hFF) begin
                            a_cnt_q <= a_cnt_q + 8'd1;
                        end
                    end
                end
                StAck: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign host_sel_o   = sel_q;
    assign host_wr_o    = wr_q;
    assign host_addr_o  = addr_q;
    assign host_wdata_o = wdata_q;
    assign a_ack_o      = a_ack_q;
    assign b_ack_o      = b_ack_q;
    assign a_rdata_o    = a_rdata_q;
    assign b_rdata_o    = b_rdata_q;
    assign a_count_o    = a_cnt_q;
    assign b_count_o    = b_cnt_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_host_arbiter.sv
// Directed bench for host_arbiter: a vector table for the basic write/read flow, plus
// hand-written sequences for round-robin, saturation, reset abort and early req drop.
module tb_host_arbiter;

    logic       host_clk_i = 1'b0;
    logic       reset_i;
    logic       a_req_i, a_wr_i, b_req_i, b_wr_i;
    logic [3:0] a_addr_i, b_addr_i, host_addr_o;
    logic [7:0] a_wdata_i, b_wdata_i, a_rdata_o, b_rdata_o;
    logic       a_ack_o, b_ack_o, host_sel_o, host_wr_o, busy_o;
    logic [7:0] host_wdata_o, host_rdata_i, a_count_o, b_count_o;

    int errors = 0;
    int checks = 0;

    always #5 host_clk_i = ~host_clk_i;

    host_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .host_clk_i  (host_clk_i),
        .reset_i     (reset_i),
        .a_req_i     (a_req_i),
        .a_wr_i      (a_wr_i),
        .a_addr_i    (a_addr_i),
        .a_wdata_i   (a_wdata_i),
        .a_ack_o     (a_ack_o),
        .a_rdata_o   (a_rdata_o),
        .b_req_i     (b_req_i),
        .b_wr_i      (b_wr_i),
        .b_addr_i    (b_addr_i),
        .b_wdata_i   (b_wdata_i),
        .b_ack_o     (b_ack_o),
        .b_rdata_o   (b_rdata_o),
        .host_sel_o  (host_sel_o),
        .host_wr_o   (host_wr_o),
        .host_addr_o (host_addr_o),
        .host_wdata_o(host_wdata_o),
        .host_rdata_i(host_rdata_i),
        .busy_o      (busy_o),
        .a_count_o   (a_count_o),
        .b_count_o   (b_count_o)
    );

    typedef struct {
        logic       a_req;
        logic       a_wr;
        logic [3:0] a_addr;
        logic [7:0] a_wdata;
        logic       b_req;
        logic       b_wr;
        logic [3:0] b_addr;
        logic [7:0] b_wdata;
        logic [7:0] rdata;
        logic       e_sel;
        logic       e_wr;
        logic [3:0] e_addr;
        logic [7:0] e_wdata;
        logic       e_a_ack;
        logic       e_b_ack;
        logic [7:0] e_a_rdata;
        logic [7:0] e_b_rdata;
        logic       e_busy;
        logic [7:0] e_a_cnt;
        logic [7:0] e_b_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge host_clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        a_req_i = 0; a_wr_i = 0; a_addr_i = 0; a_wdata_i = 0;
        b_req_i = 0; b_wr_i = 0; b_addr_i = 0; b_wdata_i = 0;
        host_rdata_i = 0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        idle_inputs();
        step();
        step();
        reset_i = 1'b0;
        check("reset_state",
              {host_sel_o, host_wr_o, host_addr_o, host_wdata_o, a_ack_o, b_ack_o,
               a_rdata_o, b_rdata_o, busy_o, a_count_o, b_count_o}, 64'd0);
    endtask

    function automatic logic [63:0] actual_vec();
        return {15'd0, host_sel_o, host_wr_o, host_addr_o, host_wdata_o, a_ack_o, b_ack_o,
                a_rdata_o, b_rdata_o, busy_o, a_count_o, b_count_o};
    endfunction

    initial begin
        int n_ack;
        int ack_cyc[8];
        logic ack_b[8];

        // a_req a_wr a_addr a_wdata b_req b_wr b_addr b_wdata rdata |
        // sel wr addr wdata a_ack b_ack a_rdata b_rdata busy a_cnt b_cnt
        vecs[0] = '{1, 1, 4'h3, 8'h5A, 0, 0, 4'h0, 8'h00, 8'h00,
                    0, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'd0, 8'd0};
        vecs[1] = '{1, 1, 4'h3, 8'h5A, 0, 0, 4'h0, 8'h00, 8'hEE,
                    1, 1, 4'h3, 8'h5A, 0, 0, 8'h00, 8'h00, 1, 8'd0, 8'd0};
        vecs[2] = '{1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 8'h00,
                    0, 0, 4'h0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 8'd1, 8'd0};
        vecs[3] = '{1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 8'h00,
                    0, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'd1, 8'd0};
        vecs[4] = '{1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 8'h5A,
                    1, 0, 4'h3, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'd1, 8'd0};
        vecs[5] = '{0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 8'h00,
                    0, 0, 4'h0, 8'h00, 1, 0, 8'h5A, 8'h00, 1, 8'd2, 8'd0};
        vecs[6] = '{0, 0, 4'h0, 8'h00, 1, 0, 4'hF, 8'h11, 8'h00,
                    0, 0, 4'h0, 8'h00, 0, 0, 8'h5A, 8'h00, 0, 8'd2, 8'd0};
        vecs[7] = '{0, 0, 4'h0, 8'h00, 1, 0, 4'hF, 8'h11, 8'hC3,
                    1, 0, 4'hF, 8'h11, 0, 0, 8'h5A, 8'h00, 1, 8'd2, 8'd0};
        vecs[8] = '{0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 8'h00,
                    0, 0, 4'h0, 8'h00, 0, 1, 8'h5A, 8'hC3, 1, 8'd2, 8'd1};
        vecs[9] = '{0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 8'h00,
                    0, 0, 4'h0, 8'h00, 0, 0, 8'h5A, 8'hC3, 0, 8'd2, 8'd1};

        do_reset();

        // Row i: outputs expected in cycle i, inputs driven during cycle i.
        for (int i = 0; i < 10; i++) begin
            check($sformatf("vec%0d", i), actual_vec(),
                  {15'd0, vecs[i].e_sel, vecs[i].e_wr, vecs[i].e_addr, vecs[i].e_wdata,
                   vecs[i].e_a_ack, vecs[i].e_b_ack, vecs[i].e_a_rdata, vecs[i].e_b_rdata,
                   vecs[i].e_busy, vecs[i].e_a_cnt, vecs[i].e_b_cnt});
            a_req_i = vecs[i].a_req; a_wr_i = vecs[i].a_wr;
            a_addr_i = vecs[i].a_addr; a_wdata_i = vecs[i].a_wdata;
            b_req_i = vecs[i].b_req; b_wr_i = vecs[i].b_wr;
            b_addr_i = vecs[i].b_addr; b_wdata_i = vecs[i].b_wdata;
            host_rdata_i = vecs[i].rdata;
            step();
        end

        // Simultaneous requests held high: grants alternate A, B, A, B, acks 3 cycles apart.
        do_reset();
        a_req_i = 1; a_addr_i = 4'h1;
        b_req_i = 1; b_addr_i = 4'h2;
        n_ack = 0;
        for (int cyc = 1; cyc <= 13; cyc++) begin
            step();
            if (a_ack_o && b_ack_o) check("both_acks", 64'd1, 64'd0);
            if ((a_ack_o || b_ack_o) && n_ack < 8) begin
                ack_cyc[n_ack] = cyc;
                ack_b[n_ack] = b_ack_o;
                n_ack++;
            end
        end
        check("rr_ack_count", 64'(n_ack), 64'd4);
        for (int k = 0; k < 4 && k < n_ack; k++) begin
            check($sformatf("rr_winner%0d", k), 64'(ack_b[k]), 64'(k % 2));
            check($sformatf("rr_ack_cycle%0d", k), 64'(ack_cyc[k]), 64'(2 + 3 * k));
        end
        idle_inputs();
        step(); step(); step();

        // 260 A accesses: count saturates at 255, B count untouched.
        do_reset();
        a_req_i = 1; a_wr_i = 1; a_addr_i = 4'h9; a_wdata_i = 8'h33;
        n_ack = 0;
        for (int cyc = 0; cyc < 1000 && n_ack < 260; cyc++) begin
            step();
            if (a_ack_o) begin
                n_ack++;
                check("sat_count_step", 64'(a_count_o), 64'((n_ack > 255) ? 255 : n_ack));
                if (n_ack == 260) a_req_i = 0;
            end
        end
        check("sat_ack_total", 64'(n_ack), 64'd260);
        idle_inputs();
        step(); step(); step();
        check("sat_a_count", 64'(a_count_o), 64'd255);
        check("sat_b_count", 64'(b_count_o), 64'd0);

        // Reset asserted during ISSUE of an A read aborts the access.
        do_reset();
        a_req_i = 1; a_addr_i = 4'h5;
        step();
        check("abort_in_issue", 64'(host_sel_o), 64'd1);
        reset_i = 1; host_rdata_i = 8'h77;
        step();
        check("abort_state",
              {61'd0, a_ack_o, busy_o, host_sel_o}, 64'd0);
        check("abort_count", 64'(a_count_o), 64'd0);
        check("abort_rdata", 64'(a_rdata_o), 64'd0);
        reset_i = 0;
        idle_inputs();
        for (int cyc = 0; cyc < 4; cyc++) begin
            step();
            check("abort_no_ack", {62'd0, a_ack_o, busy_o}, 64'd0);
        end

        // a_req dropped in ISSUE: access still completes, no further grant.
        do_reset();
        a_req_i = 1; a_addr_i = 4'h7;
        step();
        check("drop_issue", 64'(host_sel_o), 64'd1);
        a_req_i = 0; host_rdata_i = 8'h6B;
        step();
        check("drop_ack", 64'(a_ack_o), 64'd1);
        check("drop_rdata", 64'(a_rdata_o), 64'h6B);
        for (int cyc = 0; cyc < 5; cyc++) begin
            step();
            check("drop_no_regrant", {61'd0, host_sel_o, busy_o, a_ack_o}, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
